// File: rtl/ahb_lite_master_bridge.sv
// Core request port to AHB-Lite SINGLE transfer bridge, one transfer in flight.
// Optional AHB_BRIDGE_ALIGN_CHECK_EN rejects misaligned/reserved-size requests locally.
module ahb_lite_master_bridge #(
    parameter int          ADDR_W    = 32,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ahb_rd_en,
    input  logic              ahb_wr_en,
    input  logic [ADDR_W-1:0] ahb_addr,
    input  logic [31:0]       ahb_wr_data,
    input  logic [1:0]        ahb_size,
    output logic [31:0]       ahb_rd_data,
    output logic              ahb_rd_vld,
    output logic              ahb_busy,
    output logic              ahb_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ERR2
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    state_t      state;
    logic        wr_q;
    logic        bad_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        misaligned;

    assign HBURST = 3'b000;
    assign HPROT  = HPROT_VAL;

`ifdef AHB_BRIDGE_ALIGN_CHECK_EN
    assign misaligned = (ahb_size == 2'b11) ||
                        (ahb_size == 2'b01 && ahb_addr[0]) ||
                        (ahb_size == 2'b10 && ahb_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Replicate narrow write data so every lane the slave may pick is correct
    function automatic logic [31:0] place_wdata(input logic [1:0] sz,
                                                input logic [31:0] d);
        unique case (sz)
            2'b00:   place_wdata = {4{d[7:0]}};
            2'b01:   place_wdata = {2{d[15:0]}};
            default: place_wdata = d;
        endcase
    endfunction

    // Pull the addressed lane(s) down to bit 0, zero-extended
    function automatic logic [31:0] extract_rdata(input logic [1:0] sz,
                                                  input logic [1:0] lane,
                                                  input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> {lane, 3'b000};
        unique case (sz)
            2'b00:   extract_rdata = {24'h0, sh[7:0]};
            2'b01:   extract_rdata = lane[1] ? {16'h0, d[31:16]}
                                             : {16'h0, d[15:0]};
            default: extract_rdata = d;
        endcase
    endfunction

    // Transfer sequencer; all bus and core-side outputs are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_q        <= 1'b0;
            bad_q       <= 1'b0;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            HADDR       <= '0;
            HTRANS      <= TR_IDLE;
            HWRITE      <= 1'b0;
            HSIZE       <= 3'b000;
            HWDATA      <= '0;
            ahb_rd_data <= '0;
            ahb_rd_vld  <= 1'b0;
            ahb_err     <= 1'b0;
            ahb_busy    <= 1'b0;
        end else begin
            ahb_rd_vld <= 1'b0;
            ahb_err    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (ahb_rd_en || ahb_wr_en) begin
                        wr_q     <= ahb_wr_en;
                        size_q   <= ahb_size;
                        lane_q   <= ahb_addr[1:0];
                        wdata_q  <= place_wdata(ahb_size, ahb_wr_data);
                        ahb_busy <= 1'b1;
                        if (misaligned) begin
                            bad_q <= 1'b1;
                            state <= S_ERR2;
                        end else begin
                            bad_q  <= 1'b0;
                            state  <= S_ADDR;
                            HTRANS <= TR_NONSEQ;
                            HADDR  <= ahb_addr;
                            HWRITE <= ahb_wr_en;
                            HSIZE  <= {1'b0, ahb_size};
                        end
                    end
                end
                S_ADDR: begin
                    if (HREADY) begin
                        state  <= S_DATA;
                        HTRANS <= TR_IDLE;
                        if (wr_q) begin
                            HWDATA <= wdata_q;
                        end
                    end
                end
                S_DATA: begin
                    if (HREADY) begin
                        state    <= S_IDLE;
                        ahb_busy <= 1'b0;
                        if (HRESP) begin
                            ahb_err <= 1'b1;
                            if (!wr_q) begin
                                ahb_rd_vld  <= 1'b1;
                                ahb_rd_data <= '0;
                            end
                        end else if (!wr_q) begin
                            ahb_rd_vld  <= 1'b1;
                            ahb_rd_data <= extract_rdata(size_q, lane_q, HRDATA);
                        end
                    end else if (HRESP) begin
                        state <= S_ERR2;
                    end
                end
                S_ERR2: begin
                    if (HREADY || bad_q) begin
                        state    <= S_IDLE;
                        ahb_busy <= 1'b0;
                        bad_q    <= 1'b0;
                        ahb_err  <= 1'b1;
                        if (!wr_q) begin
                            ahb_rd_vld  <= 1'b1;
                            ahb_rd_data <= '0;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    ahb_busy <= 1'b0;
                    HTRANS   <= TR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ahb_lite_master_bridge.md
# ahb_lite_master_bridge

- Converts the core's single-access bus requests into AHB-Lite single transfers and returns read data, completion and error status to the core.
- Sits directly downstream of the processor core, between its `ahb_*` request port and the system AHB-Lite interconnect.
- Issues one non-pipelined SINGLE transfer at a time.
- Handles byte-lane placement for byte/halfword accesses in both directions.

## Interface
Parameters:
- `ADDR_W`, 32, address width on both sides.
- `HPROT_VAL`, 4'b0011, constant HPROT driven on every transfer (data, privileged).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `ahb_rd_en`  in  1  core read request, one-cycle pulse.
- `ahb_wr_en`  in  1  core write request, one-cycle pulse.
- `ahb_addr`  in  ADDR_W  request byte address.
- `ahb_wr_data`  in  32  write data, right-aligned.
- `ahb_size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- `ahb_rd_data`  out  32  read data, right-aligned, zero-extended.
- `ahb_rd_vld`  out  1  one-cycle pulse, `ahb_rd_data` valid.
- `ahb_busy`  out  1  bridge owns a transfer; requests ignored.
- `ahb_err`  out  1  one-cycle pulse, transfer ended in error.
- `HADDR`  out  ADDR_W  AHB address.
- `HTRANS`  out  2  IDLE (00) or NONSEQ (10) only.
- `HWRITE`  out  1  transfer direction.
- `HSIZE`  out  3  {1'b0, ahb_size}.
- `HBURST`  out  3  constant 000 (SINGLE).
- `HPROT`  out  4  `HPROT_VAL`.
- `HWDATA`  out  32  lane-placed write data.
- `HRDATA`  in  32  AHB read data.
- `HREADY`  in  1  AHB transfer ready.
- `HRESP`  in  1  0 OKAY, 1 ERROR.

## Operation
States: IDLE, ADDR, DATA, ERR2.

- **IDLE**
  - A request is sampled on an edge where `ahb_rd_en | ahb_wr_en` is high.
  - Addr, size, data and direction are latched; go to ADDR.
  - If both enables are high, the write wins and the read is dropped.
- **ADDR**
  - HTRANS=NONSEQ; HADDR/HWRITE/HSIZE come from the latched request.
  - On an edge with HREADY=1 go to DATA; otherwise hold.
- **DATA**
  - HTRANS=IDLE. HWDATA is valid for writes and held stable until completion.
  - HREADY=1, HRESP=0: complete OKAY, return to IDLE.
  - HREADY=0, HRESP=1: go to ERR2.
  - HREADY=0, HRESP=0: wait state, hold.
- **ERR2**
  - HTRANS=IDLE.
  - On HREADY=1 (second error cycle), complete with error and return to IDLE.
- **Write lane placement:** byte data is replicated to all 4 lanes; halfword data is replicated to both halves; word data passes through unchanged.
- **Read extraction:** byte reads take lane `addr[1:0]`, halfword reads take the half selected by `addr[1]`. The result is zero-extended. Sign extension is the core's job.
- **Read completion:** `ahb_rd_data` is registered and `ahb_rd_vld`=1 for one cycle. On error, `ahb_rd_data`=0 and `ahb_err`=1 in the same cycle as `ahb_rd_vld`.
- **Write completion:** no `ahb_rd_vld`. On error, `ahb_err` pulses alone.
- **`ahb_busy`:** registered, high exactly while state≠IDLE. Requests arriving while busy is high are ignored; the core must not issue them.
- **Reset:** asynchronous reset at any point, including mid-transfer, forces IDLE immediately.
- **Reset values:**
  - HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
  - `ahb_rd_data`=0, `ahb_rd_vld`=0, `ahb_err`=0, `ahb_busy`=0.
  - The interrupted transfer is abandoned; no completion is reported.

## Timing
- Request sampled at edge k.
- ADDR phase occupies cycle k..k+1 (HTRANS=NONSEQ visible after edge k).
- DATA phase starts after edge k+1.
- Zero-wait completion is at edge k+2. `ahb_rd_vld`/`ahb_err` are high and `ahb_busy` is low in cycle k+2..k+3.
- A new request is accepted at edge k+3, giving a back-to-back throughput of one transfer per 3 cycles.
- Each DATA wait state adds one cycle.
- An error response adds exactly one cycle beyond the first error cycle (ERR2).
- HTRANS never shows NONSEQ during DATA or ERR2; there is no address pipelining.

## Configuration
- **`AHB_BRIDGE_ALIGN_CHECK_EN` defined:**
  - The following never reach the bus: halfword with `addr[0]`=1, word with `addr[1:0]`≠0, and `ahb_size`=11.
  - The bridge goes IDLE→ERR2-equivalent for one cycle with HTRANS=IDLE, then reports `ahb_err` (plus `ahb_rd_vld` and 0 data for reads) at edge k+1.
- **Undefined:**
  - All requests are issued unchanged; `ahb_size`=11 passes as HSIZE=011.
  - Alignment is the slave's concern.

## Test plan
- **Zero-wait word read:** read 0x2000_0010, HRDATA=0xDEADBEEF with HREADY=1 → HTRANS=10 for one cycle, `ahb_rd_vld` at k+2, `ahb_rd_data`=0xDEADBEEF.
- **Byte write with wait states:** write byte 0x5A at 0x2000_0003 with 2 wait states → HWDATA=0x5A5A5A5A stable for 3 cycles, HSIZE=000, `ahb_busy` high 4 cycles.
- **Halfword read:** halfword read at 0x2000_0002, HRDATA=0x1234ABCD → `ahb_rd_data`=0x00001234.
- **Error response on read:** HRESP=1/HREADY=0, then HRESP=1/HREADY=1 → HTRANS=00 in both error cycles; `ahb_err` and `ahb_rd_vld` pulse together with `ahb_rd_data`=0.
- **Simultaneous requests and busy behaviour:** `ahb_rd_en` and `ahb_wr_en` high together → one write transfer. A request pulsed while busy → no second transfer.
- **Reset mid-transfer and alignment check:** `rst` asserted during DATA → HTRANS=00 and `ahb_busy`=0 with no edge needed, and no completion pulse. With `AHB_BRIDGE_ALIGN_CHECK_EN`, a word read at 0x...01 → no NONSEQ, and `ahb_err` pulses at k+1.
